n64_poll_scheduler: RTL and testbench
=====================================

Name: n64_poll_scheduler

Overview:
Transaction sequencer for the N64 one-wire link. Runs on the slow link clock.
- Periodically issues the 8-bit poll command to the bit-serial line encoder, then hands the line to the bit decoder.
- Collects the 32-bit controller report, checks for response timeout and publishes a latched report with a valid strobe.
- Sits between the top-level state logic and the send/receive primitives, replacing ad-hoc enable sequencing.

Parameters:
POLL_PERIOD, 16667, clk cycles between transaction starts (60 Hz at 1 MHz).
CMD_BYTE, 8'h01, command byte sent each poll, MSB first.
RESP_BITS, 32, data bits expected in the response (stop bit excluded).
TIMEOUT, 200, max clk cycles allowed before first response bit and between consecutive bits.

Ports:
clk  in  1  link clock.
Reset  in  1  synchronous, active-high reset.
poll_en  in  1  enables periodic polling.
tx_valid  out  1  bit offered to encoder.
tx_bit  out  1  bit value (meaningful when tx_valid=1).
tx_stop  out  1  offered bit is the console stop bit.
tx_ready  in  1  encoder accepts; transfer occurs when tx_valid & tx_ready.
rx_en  out  1  decoder may sample the line.
rx_bit_valid  in  1  one-cycle pulse: decoded bit available.
rx_bit  in  1  decoded bit value.
report  out  32  last good report, bit 31 = first bit received.
report_valid  out  1  one-cycle pulse when report updates.
timeout_err  out  1  one-cycle pulse on timeout.
err_count  out  8  saturating timeout counter.
busy  out  1  transaction in progress.

Behaviour:
- Reset (sync, active-high): state=IDLE; all counters 0; tx_valid, tx_bit, tx_stop, rx_en, report_valid, timeout_err, busy = 0; report=32'h0; err_count=0.
- Period timer:
  - Free-runs while poll_en=1 and reloads at each transaction start.
  - Reaching POLL_PERIOD-1 raises a start request.
  - The request is held if a transaction is still active. It is serviced on the cycle the FSM returns to IDLE.
  - poll_en=0 clears the timer and any pending request.
- States:
  - IDLE: busy=0. Go to SEND when the start request is set and poll_en=1.
    - The first transaction starts on the first cycle poll_en=1 after reset or after poll_en re-enable.
  - SEND: tx_valid=1, tx_bit=CMD_BYTE[7-idx]. idx advances only on a tx_valid&tx_ready cycle. After idx 7 is accepted, go to SEND_STOP.
  - SEND_STOP: tx_valid=1, tx_stop=1, tx_bit=1. Go to WAIT_RESP on acceptance.
  - WAIT_RESP: rx_en=1; timeout counter runs.
    - First rx_bit_valid: shift the bit in and go to RECV.
    - Counter reaching TIMEOUT: go to ERR.
  - RECV: rx_en=1.
    - Each rx_bit_valid shifts the bit into the shift register LSB (left-shift) and clears the timeout counter.
    - After bit RESP_BITS is received, go to DONE.
    - Timeout: go to ERR.
  - DONE: report <= shift register; report_valid=1 for exactly this cycle; rx_en=0; go to IDLE.
  - ERR: timeout_err=1 for one cycle; err_count increments, saturating at 255; report unchanged; rx_en=0; go to IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - report_valid is asserted 1 cycle after the rx_bit_valid carrying the 32nd bit.
  - timeout_err is asserted 1 cycle after the counter reaches TIMEOUT.
- Bounds and ignore rules:
  - rx_bit_valid is ignored outside WAIT_RESP/RECV. Bits beyond RESP_BITS (decoder's stop bit) are ignored.
  - tx_ready is ignored when tx_valid=0.
  - tx_valid never drops until acceptance. tx_bit is stable while waiting.
- poll_en deasserted mid-transaction: the current transaction completes (DONE or ERR), then the FSM stays in IDLE.
- Reset mid-transaction: abort immediately to reset values. A partial report is never published.
- rx_bit_valid and timeout on the same cycle: the bit wins and the counter clears.

Decomposition:
- Package n64_pkg: state enum (IDLE, SEND, SEND_STOP, WAIT_RESP, RECV, DONE, ERR), CMD_POLL=8'h01, RESP_BITS_DEF=32, button bit-index constants for the 12-bit button map used by the shifter.
- Sub-module n64_interval_timer: load/enable counter with terminal-count flag. It is instantiated twice, once for the poll period and once for the response timeout.

Test Plan:
All scenarios use POLL_PERIOD=100 and TIMEOUT=10.
1. Reset, poll_en=1, tx_ready always 1 -> tx_bit sequence 0,0,0,0,0,0,0,1, then a stop beat with tx_stop=1. rx_en rises the cycle after the stop is accepted.
2. Respond with 32 bits of 0xA5C3_0F18 -> report=32'hA5C30F18, single report_valid pulse one cycle after the last bit, busy low the next cycle. The next transaction starts 100 cycles after the previous start.
3. No response after the command -> timeout_err pulses 11 cycles after rx_en rises (counter reaches TIMEOUT, 1 cycle latency). err_count=1, report unchanged.
4. Send 20 bits, then stall 10 cycles -> ERR, report unchanged. Repeat 300 times -> err_count saturates at 8'hFF.
5. tx_ready low for 5 cycles on bit 3 -> tx_valid and tx_bit held stable and no bit skipped. Drop poll_en during RECV -> transaction completes, then no further tx_valid.
6. Assert Reset during RECV at bit 16 -> next cycle all outputs at reset values, no report_valid.

Source files
------------

// File: rtl/n64_pkg.sv
// -----------------------------------------------------------------------------
// n64_pkg
// Shared types and constants for the N64 one-wire link sequencer.
//   state_t        : transaction sequencer states
//   CMD_POLL       : controller status/poll command byte
//   RESP_BITS_DEF  : data bits in a poll response (stop bit excluded)
//   BTN_*          : bit positions of the 12-bit button map inside the
//                    32-bit report (bit 31 = first bit received)
// -----------------------------------------------------------------------------
package n64_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SEND,
      SEND_STOP,
      WAIT_RESP,
      RECV,
      DONE,
      ERR
   } state_t;

   localparam logic [7:0]  CMD_POLL      = 8'h01;
   localparam int unsigned RESP_BITS_DEF = 32;

   // Button map: report[31:24] plus report[21:18] (reserved bits 23:22 skipped)
   localparam int unsigned BTN_A       = 31;
   localparam int unsigned BTN_B       = 30;
   localparam int unsigned BTN_Z       = 29;
   localparam int unsigned BTN_START   = 28;
   localparam int unsigned BTN_D_UP    = 27;
   localparam int unsigned BTN_D_DOWN  = 26;
   localparam int unsigned BTN_D_LEFT  = 25;
   localparam int unsigned BTN_D_RIGHT = 24;
   localparam int unsigned BTN_L       = 21;
   localparam int unsigned BTN_R       = 20;
   localparam int unsigned BTN_C_UP    = 19;
   localparam int unsigned BTN_C_DOWN  = 18;

endpackage

// File: rtl/n64_interval_timer.sv
// -----------------------------------------------------------------------------
// n64_interval_timer
// Up-counter with synchronous load-to-zero and a terminal-count flag.
//   clk    : link clock
//   Reset  : synchronous, active-high reset (clears the count)
//   i_load : clear the count to zero (dominates i_en)
//   i_en   : count enable; the count wraps to zero after TERM
//   o_tc   : high while enabled and the count equals TERM
// -----------------------------------------------------------------------------
module n64_interval_timer #(
   parameter int unsigned TERM = 10
) (
   input  logic clk,
   input  logic Reset,
   input  logic i_load,
   input  logic i_en,
   output logic o_tc
);

   localparam int unsigned W = (TERM > 0) ? $clog2(TERM + 1) : 1;
   localparam logic [W-1:0] TERM_V = W'(TERM);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (Reset || i_load) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= (r_count == TERM_V) ? '0 : r_count + 1'b1;
      end
   end

   assign o_tc = i_en && (r_count == TERM_V);

endmodule

// File: rtl/n64_poll_scheduler.sv
// -----------------------------------------------------------------------------
// n64_poll_scheduler
// Periodic poll transaction sequencer for the N64 one-wire link.
// Sends CMD_BYTE (MSB first) plus a console stop bit to the line encoder,
// then collects RESP_BITS decoded bits, publishing them as a latched report
// or flagging a response timeout.
//   clk, Reset         : link clock, synchronous active-high reset
//   poll_en            : enables periodic polling
//   tx_valid/bit/stop  : bit offered to encoder; tx_ready accepts it
//   rx_en              : decoder may sample the line
//   rx_bit_valid/bit   : decoded bit strobe and value
//   report/report_valid: last good report (bit 31 first received), pulse
//   timeout_err        : pulse on response timeout
//   err_count          : saturating timeout count
//   busy               : transaction in progress
// -----------------------------------------------------------------------------
module n64_poll_scheduler
   import n64_pkg::*;
#(
   parameter int unsigned POLL_PERIOD = 16667,
   parameter logic [7:0]  CMD_BYTE    = CMD_POLL,
   parameter int unsigned RESP_BITS   = RESP_BITS_DEF,
   parameter int unsigned TIMEOUT     = 200
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic        poll_en,
   output logic        tx_valid,
   output logic        tx_bit,
   output logic        tx_stop,
   input  logic        tx_ready,
   output logic        rx_en,
   input  logic        rx_bit_valid,
   input  logic        rx_bit,
   output logic [31:0] report,
   output logic        report_valid,
   output logic        timeout_err,
   output logic [7:0]  err_count,
   output logic        busy
);

   state_t       r_state;
   state_t       w_next;
   logic [2:0]   r_idx;
   logic [5:0]   r_bit_cnt;
   logic [31:0]  r_shift;
   logic [31:0]  r_report;
   logic [7:0]   r_err_cnt;
   logic         r_en_q;
   logic         r_pend;

   logic         w_period_tc;
   logic         w_resp_tc;
   logic         w_start;
   logic         w_rx_phase;
   logic         w_rx_take;
   logic         w_last;
   logic [31:0]  w_shift_next;

   // A rising poll_en (r_en_q low) counts as an immediate start request.
   assign w_start      = (r_state == IDLE) && poll_en && (r_pend || w_period_tc || !r_en_q);
   assign w_rx_phase   = (r_state == WAIT_RESP) || (r_state == RECV);
   assign w_rx_take    = w_rx_phase && rx_bit_valid;
   assign w_last       = (r_bit_cnt == 6'(RESP_BITS - 1));
   assign w_shift_next = {r_shift[30:0], rx_bit};

   n64_interval_timer #(.TERM(POLL_PERIOD - 1)) u_period_timer (
      .clk    (clk),
      .Reset  (Reset),
      .i_load (w_start || !poll_en),
      .i_en   (poll_en),
      .o_tc   (w_period_tc)
   );

   // Cleared by every accepted bit, so it measures silence since the last bit.
   n64_interval_timer #(.TERM(TIMEOUT)) u_resp_timer (
      .clk    (clk),
      .Reset  (Reset),
      .i_load (!w_rx_phase || rx_bit_valid),
      .i_en   (w_rx_phase),
      .o_tc   (w_resp_tc)
   );

   always_comb begin
      w_next       = r_state;
      tx_valid     = 1'b0;
      tx_bit       = 1'b0;
      tx_stop      = 1'b0;
      rx_en        = 1'b0;
      report_valid = 1'b0;
      timeout_err  = 1'b0;
      busy         = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (w_start) w_next = SEND;
         end
         SEND: begin
            tx_valid = 1'b1;
            tx_bit   = CMD_BYTE[3'd7 - r_idx];
            if (tx_ready && (r_idx == 3'd7)) w_next = SEND_STOP;
         end
         SEND_STOP: begin
            tx_valid = 1'b1;
            tx_stop  = 1'b1;
            tx_bit   = 1'b1;
            if (tx_ready) w_next = WAIT_RESP;
         end
         WAIT_RESP, RECV: begin
            rx_en = 1'b1;
            // A bit arriving on the timeout cycle takes priority.
            if (rx_bit_valid) w_next = w_last ? DONE : RECV;
            else if (w_resp_tc) w_next = ERR;
         end
         DONE: begin
            report_valid = 1'b1;
            w_next       = IDLE;
         end
         ERR: begin
            timeout_err = 1'b1;
            w_next      = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_report  <= '0;
         r_err_cnt <= '0;
         r_en_q    <= 1'b0;
         r_pend    <= 1'b0;
      end else begin
         r_state <= w_next;
         r_en_q  <= poll_en;

         if (!poll_en || w_start) r_pend <= 1'b0;
         else if (w_period_tc)    r_pend <= 1'b1;

         if (r_state == IDLE)                  r_idx <= '0;
         else if (r_state == SEND && tx_ready) r_idx <= r_idx + 3'd1;

         if (r_state == IDLE)  r_bit_cnt <= '0;
         else if (w_rx_take)   r_bit_cnt <= r_bit_cnt + 6'd1;

         if (w_rx_take) r_shift <= w_shift_next;

         // Latched on the final bit so report is already new while DONE pulses.
         if (w_rx_take && w_last) r_report <= w_shift_next;

         if ((w_next == ERR) && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign report    = r_report;
   assign err_count = r_err_cnt;

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// -----------------------------------------------------------------------------
// tb_n64_poll_scheduler
// Scoreboard bench: the stimulus side pushes expected encoder beats and
// expected transaction outcomes; a negedge monitor pops and compares them
// whenever the DUT accepts a beat or pulses report_valid / timeout_err.
// -----------------------------------------------------------------------------
module tb_n64_poll_scheduler;

   localparam int unsigned PP  = 100;
   localparam int unsigned TO  = 10;
   localparam logic [7:0]  CMD = 8'h01;

   logic        clk = 1'b0;
   logic        Reset, poll_en, tx_ready, rx_bit_valid, rx_bit;
   logic        tx_valid, tx_bit, tx_stop, rx_en, report_valid, timeout_err, busy;
   logic [31:0] report;
   logic [7:0]  err_count;

   n64_poll_scheduler #(
      .POLL_PERIOD (PP),
      .CMD_BYTE    (CMD),
      .RESP_BITS   (32),
      .TIMEOUT     (TO)
   ) dut (
      .clk          (clk),
      .Reset        (Reset),
      .poll_en      (poll_en),
      .tx_valid     (tx_valid),
      .tx_bit       (tx_bit),
      .tx_stop      (tx_stop),
      .tx_ready     (tx_ready),
      .rx_en        (rx_en),
      .rx_bit_valid (rx_bit_valid),
      .rx_bit       (rx_bit),
      .report       (report),
      .report_valid (report_valid),
      .timeout_err  (timeout_err),
      .err_count    (err_count),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_err;
      logic [31:0] rep;
      logic [7:0]  errs;
   } ev_t;

   ev_t         exp_q[$];
   logic [1:0]  exp_tx[$];
   int          checks = 0;
   int          failures = 0;
   int          cycle = 0;
   int          t_start = 0;
   logic [31:0] m_report = '0;
   int          m_errs = 0;

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic finish_now();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // which: 0 = tx_valid high, 1 = rx_en high, 2 = busy low
   task automatic wait_sig(input int which, input int budget);
      int  n = 0;
      bit  hit = 1'b0;
      while (!hit) begin
         case (which)
            0:       hit = tx_valid;
            1:       hit = rx_en;
            default: hit = !busy;
         endcase
         if (!hit) begin
            tick();
            n++;
            if (n > budget) begin
               checks++;
               failures++;
               $display("FAIL wait_%0d: condition not seen within %0d cycles", which, budget);
               finish_now();
            end
         end
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tx_valid"},     tx_valid, 0);
      chk({tag, "_tx_bit"},       tx_bit, 0);
      chk({tag, "_tx_stop"},      tx_stop, 0);
      chk({tag, "_rx_en"},        rx_en, 0);
      chk({tag, "_report_valid"}, report_valid, 0);
      chk({tag, "_timeout_err"},  timeout_err, 0);
      chk({tag, "_busy"},         busy, 0);
      chk({tag, "_report"},       report, 0);
      chk({tag, "_err_count"},    err_count, 0);
   endtask

   // Command phase: expected beats are the command byte MSB first, then a stop beat.
   task automatic do_tx(input int stall_beat, input int stall_len, input bit rnd);
      logic [7:0] c = CMD;
      int         len;
      logic       b;
      for (int k = 0; k < 8; k++) exp_tx.push_back({1'b0, c[7-k]});
      exp_tx.push_back(2'b11);
      wait_sig(0, 300);
      t_start = cycle;
      for (int k = 0; k < 9; k++) begin
         len = (k == stall_beat) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
         if (len > 0) begin
            tx_ready = 1'b0;
            b = tx_bit;
            for (int s = 0; s < len; s++) begin
               tick();
               chk("tx_hold_valid", tx_valid, 1);
               chk("tx_hold_bit", tx_bit, b);
            end
            tx_ready = 1'b1;
         end
         tick();
      end
      chk("rx_en_after_stop", rx_en, 1);
      chk("tx_idle_after_stop", tx_valid, 0);
   endtask

   task automatic send_bit(input logic b);
      rx_bit_valid = 1'b1;
      rx_bit       = b;
      tick();
      rx_bit_valid = 1'b0;
      rx_bit       = 1'($urandom);
   endtask

   // Response phase: a full 32-bit reply with gaps <= TO yields a report,
   // anything shorter ends in a timeout.
   task automatic do_rx(input logic [31:0] word, input int nbits, input int max_gap, input int drop_at);
      ev_t ev;
      if (nbits == 32) begin
         m_report  = word;
         ev.is_err = 1'b0;
      end else begin
         if (m_errs < 255) m_errs++;
         ev.is_err = 1'b1;
      end
      ev.rep  = m_report;
      ev.errs = 8'(m_errs);
      exp_q.push_back(ev);
      for (int i = 0; i < nbits; i++) begin
         if (i == drop_at) poll_en = 1'b0;
         repeat ($urandom_range(0, max_gap)) tick();
         send_bit(word[31-i]);
      end
      if (nbits == 32) begin
         chk("report_valid_latency", report_valid, 1);
         send_bit(1'b1);   // decoder stop bit, must be ignored
         chk("busy_after_done", busy, 0);
      end else begin
         wait_sig(2, 50);
      end
   endtask

   // Monitor
   ev_t        mon_ev;
   logic [1:0] mon_tx;
   always @(negedge clk) begin
      if (!Reset) begin
         if (tx_valid && tx_ready) begin
            if (exp_tx.size() == 0) begin
               chk("tx_unexpected_beat", {tx_stop, tx_bit}, 2'bxx);
            end else begin
               mon_tx = exp_tx.pop_front();
               chk("tx_beat", {30'd0, tx_stop, tx_bit}, {30'd0, mon_tx});
            end
         end
         if (report_valid || timeout_err) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_event", {report_valid, timeout_err}, 0);
            end else begin
               mon_ev = exp_q.pop_front();
               chk("event_kind", {report_valid, timeout_err}, mon_ev.is_err ? 2'b01 : 2'b10);
               chk("report", report, mon_ev.rep);
               chk("err_count", err_count, mon_ev.errs);
            end
         end
      end
   end

   initial begin
      int          first;
      int          w;
      int          n;
      bit          any_tx;
      logic [31:0] word;

      Reset = 1'b1; poll_en = 1'b0; tx_ready = 1'b1; rx_bit_valid = 1'b0; rx_bit = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      poll_en = 1'b1;
      tick();
      Reset = 1'b0;

      // Command sequence, known report, poll period
      do_tx(-1, 0, 1'b0);
      first = t_start;
      do_rx(32'hA5C3_0F18, 32, 0, -1);
      chk("report_value", report, 32'hA5C3_0F18);
      do_tx(-1, 0, 1'b0);
      chk("poll_period", 32'(t_start - first), PP);
      do_rx(32'($urandom), 32, int'(TO), -1);

      // No response: timeout latency
      do_tx(-1, 0, 1'b0);
      w = cycle;
      m_errs++;
      exp_q.push_back('{1'b1, m_report, 8'(m_errs)});
      n = 0;
      while (!timeout_err && n < 40) begin
         tick();
         n++;
      end
      chk("timeout_latency", 32'(cycle - w), 11);
      wait_sig(2, 20);

      // Random good transactions, gaps up to the timeout boundary
      repeat (20) begin
         do_tx(-1, 0, 1'b1);
         do_rx(32'($urandom), 32, int'(TO), -1);
      end

      // Truncated responses until err_count saturates
      for (int i = 0; i < 300; i++) begin
         do_tx(-1, 0, 1'b1);
         do_rx(32'($urandom), (i == 0) ? 20 : int'($urandom_range(0, 31)), 3, -1);
      end
      chk("err_saturated", err_count, 8'hFF);

      // Encoder stall on bit 3, poll_en dropped during RECV
      do_tx(3, 5, 1'b0);
      do_rx(32'($urandom), 32, 2, 10);
      any_tx = 1'b0;
      repeat (250) begin
         tick();
         if (tx_valid || busy) any_tx = 1'b1;
      end
      chk("no_txn_after_disable", any_tx, 0);
      poll_en = 1'b1;
      tick();
      chk("restart_immediate", tx_valid, 1);
      do_tx(-1, 0, 1'b0);
      do_rx(32'($urandom), 32, 2, -1);

      // Reset in the middle of a response
      do_tx(-1, 0, 1'b0);
      word = 32'($urandom);
      for (int i = 0; i < 16; i++) send_bit(word[31-i]);
      Reset = 1'b1;
      tick();
      check_reset_outputs("midreset");
      m_report = '0;
      m_errs   = 0;
      Reset    = 1'b0;
      chk("no_pending_events", exp_q.size(), 0);
      do_tx(-1, 0, 1'b0);
      do_rx(32'($urandom), 32, 3, -1);

      repeat (5) tick();
      chk("scoreboard_drained", exp_q.size() + exp_tx.size(), 0);
      finish_now();
   end

endmodule
